// File: rtl/execute_pipe_pkg.sv
// Shared encodings for the LEGv8 execute stage: ALU opcodes, forwarding selects
// and the multiplier sequencing states.
package execute_pkg;

  localparam logic [3:0] ALU_AND   = 4'b0000;
  localparam logic [3:0] ALU_OR    = 4'b0001;
  localparam logic [3:0] ALU_ADD   = 4'b0010;
  localparam logic [3:0] ALU_SUB   = 4'b0110;
  localparam logic [3:0] ALU_PASSB = 4'b0111;
  localparam logic [3:0] ALU_NOR   = 4'b1100;

  localparam logic [1:0] FWD_RF  = 2'b00;
  localparam logic [1:0] FWD_WB  = 2'b01;
  localparam logic [1:0] FWD_MEM = 2'b10;

  typedef enum logic [1:0] {
    IDLE,
    MUL,
    DONE
  } mul_state_t;

endpackage

// File: rtl/execute_pipe_if.sv
// ID/EX -> EX/MEM bus of the execute stage. The pipeline control side is the
// master; the execute stage itself is the slave.
interface execute_pipe_if #(
  parameter int N    = 64,
  parameter int RD_W = 5
);

  logic            valid_E;
  logic            flush_E;
  logic            AluSrc;
  logic [3:0]      AluControl;
  logic            mul_E;
  logic [1:0]      forwardA;
  logic [1:0]      forwardB;
  logic [N-1:0]    PC_E;
  logic [N-1:0]    signImm_E;
  logic [N-1:0]    readData1_E;
  logic [N-1:0]    readData2_E;
  logic [N-1:0]    fwdData_M;
  logic [N-1:0]    fwdData_W;
  logic [RD_W-1:0] rd_E;

  logic            busy_E;
  logic            valid_M;
  logic            zero_M;
  logic [N-1:0]    PCBranch_M;
  logic [N-1:0]    aluResult_M;
  logic [N-1:0]    writeData_M;
  logic [RD_W-1:0] rd_M;

  modport master (
    output valid_E, flush_E, AluSrc, AluControl, mul_E, forwardA, forwardB,
           PC_E, signImm_E, readData1_E, readData2_E, fwdData_M, fwdData_W, rd_E,
    input  busy_E, valid_M, zero_M, PCBranch_M, aluResult_M, writeData_M, rd_M
  );

  modport slave (
    input  valid_E, flush_E, AluSrc, AluControl, mul_E, forwardA, forwardB,
           PC_E, signImm_E, readData1_E, readData2_E, fwdData_M, fwdData_W, rd_E,
    output busy_E, valid_M, zero_M, PCBranch_M, aluResult_M, writeData_M, rd_M
  );

endinterface

// File: rtl/execute_pipe_mul_iter.sv
// Iterative shift-add multiplier retiring MUL_STEP multiplier bits per cycle.
// Only the low N bits of the product are kept, so signedness does not matter.
module mul_iter #(
  parameter int N        = 64,
  parameter int MUL_STEP = 4
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         start,
  input  logic         abort,
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  output logic [N-1:0] product,
  output logic         last
);

  localparam int K  = N / MUL_STEP;
  localparam int CW = $clog2(K + 1);

  logic [N-1:0]  acc;
  logic [N-1:0]  mcand;
  logic [N-1:0]  mplier;
  logic [N-1:0]  partial;
  logic [CW-1:0] count;

  always_comb begin
    partial = '0;
    for (int i = 0; i < MUL_STEP; i++) begin
      if (mplier[i]) partial = partial + (mcand << i);
    end
  end

  // count == 0 means idle; the accumulator then holds the last finished product
  always_ff @(posedge clk) begin
    if (reset || abort) begin
      acc    <= '0;
      mcand  <= '0;
      mplier <= '0;
      count  <= '0;
    end else if (start) begin
      acc    <= '0;
      mcand  <= a;
      mplier <= b;
      count  <= CW'(K);
    end else if (count != '0) begin
      acc    <= acc + partial;
      mcand  <= mcand << MUL_STEP;
      mplier <= mplier >> MUL_STEP;
      count  <= count - CW'(1);
    end
  end

  assign product = acc;
  assign last    = (count == CW'(1));

endmodule

// File: rtl/execute_pipe.sv
// LEGv8 execute stage: operand forwarding, ALU, branch target adder, iterative
// MUL with stall handshake, and the EX/MEM pipeline register.
module execute_pipe
  import execute_pkg::*;
#(
  parameter int N        = 64,
  parameter int MUL_STEP = 4,
  parameter int RD_W     = 5
) (
  input logic           clk,
  input logic           reset,
  execute_pipe_if.slave bus
);

  mul_state_t   state;
  logic [N-1:0] src_a;
  logic [N-1:0] src_b;
  logic [N-1:0] alu_b;
  logic [N-1:0] alu_result;
  logic [N-1:0] pc_branch;
  logic [N-1:0] product;
  logic         mul_start;
  logic         mul_last;

  always_comb begin
    case (bus.forwardA)
      FWD_RF:  src_a = bus.readData1_E;
      FWD_WB:  src_a = bus.fwdData_W;
      FWD_MEM: src_a = bus.fwdData_M;
      default: src_a = bus.readData1_E;
    endcase
  end

  always_comb begin
    case (bus.forwardB)
      FWD_RF:  src_b = bus.readData2_E;
      FWD_WB:  src_b = bus.fwdData_W;
      FWD_MEM: src_b = bus.fwdData_M;
      default: src_b = bus.readData2_E;
    endcase
  end

  assign alu_b     = bus.AluSrc ? bus.signImm_E : src_b;
  assign pc_branch = bus.PC_E + (bus.signImm_E << 2);

  always_comb begin
    case (bus.AluControl)
      ALU_AND:   alu_result = src_a & alu_b;
      ALU_OR:    alu_result = src_a | alu_b;
      ALU_ADD:   alu_result = src_a + alu_b;
      ALU_SUB:   alu_result = src_a - alu_b;
      ALU_PASSB: alu_result = alu_b;
      ALU_NOR:   alu_result = ~(src_a | alu_b);
      default:   alu_result = '0;
    endcase
  end

  assign mul_start  = (state == IDLE) && bus.valid_E && bus.mul_E && !bus.flush_E;
  assign bus.busy_E = !reset && !bus.flush_E && (mul_start || state == MUL);

  mul_iter #(
    .N        (N),
    .MUL_STEP (MUL_STEP)
  ) u_mul (
    .clk     (clk),
    .reset   (reset),
    .start   (mul_start),
    .abort   (bus.flush_E),
    .a       (src_a),
    .b       (src_b),
    .product (product),
    .last    (mul_last)
  );

  // In DONE, writeData/PCBranch/rd come from ID/EX inputs that upstream held during the stall
  always_ff @(posedge clk) begin
    if (reset) begin
      state           <= IDLE;
      bus.valid_M     <= 1'b0;
      bus.zero_M      <= 1'b0;
      bus.aluResult_M <= '0;
      bus.writeData_M <= '0;
      bus.PCBranch_M  <= '0;
      bus.rd_M        <= '0;
    end else if (bus.flush_E) begin
      state       <= IDLE;
      bus.valid_M <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (mul_start) begin
            state       <= MUL;
            bus.valid_M <= 1'b0;
          end else begin
            bus.valid_M     <= bus.valid_E;
            bus.aluResult_M <= alu_result;
            bus.zero_M      <= (alu_result == '0);
            bus.writeData_M <= src_b;
            bus.PCBranch_M  <= pc_branch;
            bus.rd_M        <= bus.rd_E;
          end
        end
        MUL: begin
          bus.valid_M <= 1'b0;
          if (mul_last) state <= DONE;
        end
        DONE: begin
          state           <= IDLE;
          bus.valid_M     <= 1'b1;
          bus.aluResult_M <= product;
          bus.zero_M      <= (product == '0);
          bus.writeData_M <= src_b;
          bus.PCBranch_M  <= pc_branch;
          bus.rd_M        <= bus.rd_E;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
